// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore sequencing controller for the multicycle MIPS datapath
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high; forces state FETCH, all outputs 0
//   op_code[5:0]   IR[31:26], stable from DECODE until the next FETCH
//   mem_ready      memory completed the current access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load qualified by ALU zero (beq)
//   i_or_d         memory address select: 0 = PC, 1 = ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       instruction register load
//   reg_dst        write register select: 0 = rt, 1 = rd
//   mem_to_reg     writeback data select: 0 = ALUOut, 1 = MDR
//   reg_write      register file write enable
//   alu_src_a      ALU A select: 0 = PC, 1 = rs
//   alu_src_b[1:0] ALU B select: 00 rt, 01 const 4, 10 sext imm, 11 sext imm<<2
//   alu_op[1:0]    00 add, 01 sub, 10 use funct
//   pc_source[1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   illegal_op     1-cycle pulse in DECODE for an unsupported opcode
//   instr_done     1-cycle pulse in the last state of each instruction
//   state[3:0]     current state code (debug)

module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_code,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  state_t state_q;
  state_t state_d;
  logic   rdy;

  // With a fixed 1-cycle memory the handshake input is ignored entirely.
  assign rdy   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_code)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      // Only lw and sw reach MEMADR, so anything but lw is treated as sw.
      S_MEMADR:  state_d = (op_code == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:    state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_ADDI_WB: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    pc_source     = PCS_ALU;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    // Reset gates the decode so no strobe (e.g. FETCH's mem_read) escapes
    // while the state register is being held.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          // PC+4 and IR load commit only on the cycle the fetch completes.
          ir_write  = rdy;
          pc_write  = rdy;
        end
        S_DECODE: begin
          // Speculatively compute the branch target into ALUOut.
          alu_src_b = SRCB_IMMSH;
          case (op_code)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
            default:                                  illegal_op = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = rdy;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_RT;
          alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRCB_RT;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCS_ALUOUT;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCS_JUMP;
          instr_done = 1'b1;
        end
        S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm

module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] outs;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       reset0;
  logic [5:0] op_code;
  logic       mem_ready;

  logic       pc_write1, pc_write_cond1, i_or_d1, mem_read1, mem_write1, ir_write1;
  logic       reg_dst1, mem_to_reg1, reg_write1, alu_src_a1, illegal_op1, instr_done1;
  logic [1:0] alu_src_b1, alu_op1, pc_source1;
  logic [3:0] state1;

  logic       pc_write0, pc_write_cond0, i_or_d0, mem_read0, mem_write0, ir_write0;
  logic       reg_dst0, mem_to_reg0, reg_write0, alu_src_a0, illegal_op0, instr_done0;
  logic [1:0] alu_src_b0, alu_op0, pc_source0;
  logic [3:0] state0;

  logic [17:0] outs1, outs0;

  int checks   = 0;
  int failures = 0;
  int exp_done = 0;
  int got_done = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .op_code(op_code), .mem_ready(mem_ready),
    .pc_write(pc_write1), .pc_write_cond(pc_write_cond1), .i_or_d(i_or_d1),
    .mem_read(mem_read1), .mem_write(mem_write1), .ir_write(ir_write1),
    .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .reg_write(reg_write1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_op(alu_op1),
    .pc_source(pc_source1), .illegal_op(illegal_op1), .instr_done(instr_done1),
    .state(state1)
  );

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .op_code(op_code), .mem_ready(1'b0),
    .pc_write(pc_write0), .pc_write_cond(pc_write_cond0), .i_or_d(i_or_d0),
    .mem_read(mem_read0), .mem_write(mem_write0), .ir_write(ir_write0),
    .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .reg_write(reg_write0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
    .pc_source(pc_source0), .illegal_op(illegal_op0), .instr_done(instr_done0),
    .state(state0)
  );

  assign outs1 = {pc_write1, pc_write_cond1, i_or_d1, mem_read1, mem_write1, ir_write1,
                  reg_dst1, mem_to_reg1, reg_write1, alu_src_a1, alu_src_b1, alu_op1,
                  pc_source1, illegal_op1, instr_done1};
  assign outs0 = {pc_write0, pc_write_cond0, i_or_d0, mem_read0, mem_write0, ir_write0,
                  reg_dst0, mem_to_reg0, reg_write0, alu_src_a0, alu_src_b0, alu_op0,
                  pc_source0, illegal_op0, instr_done0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [17:0] exp_out(input logic [3:0] st, input logic r, input logic [5:0] op);
    logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, ill, dn;
    logic [1:0] sb, ao, ps;
    {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, ill, dn} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; irw = r; pw = r; end
      4'd1:  begin
               sb  = 2'b11;
               ill = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                       op == 6'b000100 || op == 6'b000010 || op == 6'b001000);
             end
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin m2r = 1; rw = 1; dn = 1; end
      4'd5:  begin mw = 1; iod = 1; dn = r; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; dn = 1; end
      4'd8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
      4'd9:  begin pw = 1; ps = 2'b10; dn = 1; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: begin rw = 1; dn = 1; end
      default: begin end
    endcase
    return {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, ill, dn};
  endfunction

  task automatic push_e(input logic [5:0] op, input logic rdy, input logic [3:0] st, input bit hs);
    ent_t e;
    e.op   = op;
    e.rdy  = rdy;
    e.st   = st;
    e.outs = exp_out(st, hs ? rdy : 1'b1, op);
    if (e.outs[0]) exp_done++;
    q.push_back(e);
  endtask

  // Full instruction: FETCH with fw wait cycles, DECODE, then the op's path
  // with mw memory wait cycles. op_code is scrambled during FETCH.
  task automatic push_instr(input logic [5:0] op, input int fw, input int mw, input bit hs);
    for (int i = 0; i < fw; i++) push_e(6'($urandom), 1'b0, 4'd0, hs);
    push_e(6'($urandom), 1'b1, 4'd0, hs);
    push_e(op, 1'($urandom), 4'd1, hs);
    case (op)
      6'b000000: begin push_e(op, 1'($urandom), 4'd6, hs); push_e(op, 1'($urandom), 4'd7, hs); end
      6'b100011: begin
                   push_e(op, 1'($urandom), 4'd2, hs);
                   for (int i = 0; i < mw; i++) push_e(op, 1'b0, 4'd3, hs);
                   push_e(op, 1'b1, 4'd3, hs);
                   push_e(op, 1'($urandom), 4'd4, hs);
                 end
      6'b101011: begin
                   push_e(op, 1'($urandom), 4'd2, hs);
                   for (int i = 0; i < mw; i++) push_e(op, 1'b0, 4'd5, hs);
                   push_e(op, 1'b1, 4'd5, hs);
                 end
      6'b000100: push_e(op, 1'($urandom), 4'd8, hs);
      6'b000010: push_e(op, 1'($urandom), 4'd9, hs);
      6'b001000: begin push_e(op, 1'($urandom), 4'd10, hs); push_e(op, 1'($urandom), 4'd11, hs); end
      default:   begin end
    endcase
  endtask

  task automatic run_q(input bit hs);
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      op_code   = e.op;
      mem_ready = e.rdy;
      #1;
      if (hs) begin
        check("state", 32'(state1), 32'(e.st));
        check("outs", 32'(outs1), 32'(e.outs));
        if (instr_done1) got_done++;
      end else begin
        check("state_hs0", 32'(state0), 32'(e.st));
        check("outs_hs0", 32'(outs0), 32'(e.outs));
        if (instr_done0) got_done++;
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    reset0    = 1'b1;
    mem_ready = 1'b1;
    op_code   = 6'b000000;
    #2;
    check("rst_state", 32'(state1), 32'd0);
    check("rst_outs", 32'(outs1), 32'd0);
    check("rst_outs_hs0", 32'(outs0), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    push_instr(6'b000000, 0, 0, 1'b1);
    push_instr(6'b100011, 2, 3, 1'b1);
    push_instr(6'b101011, 0, 0, 1'b1);
    push_instr(6'b000100, 0, 0, 1'b1);
    push_instr(6'b000010, 0, 0, 1'b1);
    push_instr(6'b111111, 0, 0, 1'b1);
    push_instr(6'b001000, 0, 0, 1'b1);
    push_instr(6'b101011, 1, 2, 1'b1);
    push_instr(6'b100011, 0, 0, 1'b1);
    push_instr(6'b010101, 1, 0, 1'b1);
    push_instr(6'b000000, 0, 0, 1'b1);
    // Partial sw stalled in MEMWR, interrupted by reset below.
    push_e(6'h3f, 1'b1, 4'd0, 1'b1);
    push_e(6'b101011, 1'b0, 4'd1, 1'b1);
    push_e(6'b101011, 1'b0, 4'd2, 1'b1);
    push_e(6'b101011, 1'b0, 4'd5, 1'b1);
    push_e(6'b101011, 1'b0, 4'd5, 1'b1);
    run_q(1'b1);

    #2 reset = 1'b1;
    #1;
    check("midrst_state", 32'(state1), 32'd0);
    check("midrst_memwrite", 32'(mem_write1), 32'd0);
    check("midrst_outs", 32'(outs1), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    push_instr(6'b000000, 1, 0, 1'b1);
    push_e(6'h00, 1'b0, 4'd0, 1'b1);
    run_q(1'b1);
    check("done_count", 32'(got_done), 32'(exp_done));

    // Fixed 1-cycle memory: mem_ready tied low must not stall lw.
    reset = 1'b1;
    @(posedge clk); #1 reset0 = 1'b0;
    push_instr(6'b100011, 0, 0, 1'b0);
    push_e(6'h00, 1'b0, 4'd0, 1'b0);
    run_q(1'b0);
    check("done_count_hs0", 32'(got_done), 32'(exp_done));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
